// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: major opcodes, the canonical NOP word and the
// fetch FSM state encoding.
package riscv_pkg;

   localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: sequential pc+4 or a word-aligned branch target pc+immext.
module pc_next_mux (
   input  logic [31:0] pc_i,
   input  logic [31:0] immext_i,
   input  logic        pcsrc_i,
   output logic [31:0] pcplus4_o,
   output logic [31:0] pc_next_o
);

   logic [31:0] branch_target;

   assign pcplus4_o     = pc_i + 32'd4;
   assign branch_target = pc_i + immext_i;

   // Targets are forced onto a word boundary; wrap-around is plain 32-bit modulo.
   assign pc_next_o = pcsrc_i ? {branch_target[31:2], 2'b00} : pcplus4_o;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request a word, hold it for decode
// until retired, then advance the PC and fetch again.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   // Request/ack: imem_req stays high with a stable imem_addr until imem_ack
   // is sampled high on a rising edge; imem_ack outside a request is ignored.
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_ack,
   input  logic [31:0]  imem_rdata,
   input  logic         stall,
   input  logic         pcsrc,
   input  logic [31:0]  immext,
   output logic [31:0]  instr,
   output logic [6:0]   opcode,
   output logic [2:0]   funct3,
   output logic         funct7,
   output logic         instr_valid,
   output logic [31:0]  pc,
   output logic [31:0]  pcplus4,
   output logic [31:0]  instret,
   output fetch_state_e fsm_state
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  instret_q, instret_d;
   logic [31:0]  pc_next;

   pc_next_mux u_pc_next_mux (
      .pc_i      (pc_q),
      .immext_i  (immext),
      .pcsrc_i   (pcsrc),
      .pcplus4_o (pcplus4),
      .pc_next_o (pc_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      instret_d = instret_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = VALID;
            end
         end
         VALID: begin
            // Retire: branch inputs are only looked at on this edge.
            if (!stall) begin
               pc_d      = pc_next;
               instret_d = instret_q + 32'd1;
               state_d   = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = {pc_q[31:2], 2'b00};
   assign instr_valid = (state_q == VALID);
   assign instr       = instr_q;
   assign opcode      = instr_q[6:0];
   assign funct3      = instr_q[14:12];
   assign funct7      = instr_q[30];
   assign pc          = pc_q;
   assign instret     = instret_q;
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the fetch loop.
module tb_fetch_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        stall = 1'b1;
   logic        pcsrc = 1'b0;
   logic [31:0] immext = 32'd0;

   logic         a_imem_req, a_funct7, a_instr_valid;
   logic [31:0]  a_imem_addr, a_instr, a_pc, a_pcplus4, a_instret;
   logic [6:0]   a_opcode;
   logic [2:0]   a_funct3;
   fetch_state_e a_fsm_state;

   logic         b_imem_req, b_funct7, b_instr_valid;
   logic [31:0]  b_imem_addr, b_instr, b_pc, b_pcplus4, b_instret;
   logic [6:0]   b_opcode;
   logic [2:0]   b_funct3;
   fetch_state_e b_fsm_state;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut_a (
      .clk(clk), .reset(reset),
      .imem_req(a_imem_req), .imem_addr(a_imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .pcsrc(pcsrc), .immext(immext),
      .instr(a_instr), .opcode(a_opcode), .funct3(a_funct3), .funct7(a_funct7),
      .instr_valid(a_instr_valid), .pc(a_pc), .pcplus4(a_pcplus4),
      .instret(a_instret), .fsm_state(a_fsm_state)
   );

   // Same stimulus with a reset PC of -4: its PC trajectory is always dut_a's minus 4.
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
      .clk(clk), .reset(reset),
      .imem_req(b_imem_req), .imem_addr(b_imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .pcsrc(pcsrc), .immext(immext),
      .instr(b_instr), .opcode(b_opcode), .funct3(b_funct3), .funct7(b_funct7),
      .instr_valid(b_instr_valid), .pc(b_pc), .pcplus4(b_pcplus4),
      .instret(b_instret), .fsm_state(b_fsm_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: boot cycle, then fetch/hold/retire loop; PC for dut_a starts at 0.
   bit          m_booting;
   bit          m_fetching;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_instret;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_booting  = 1'b1;
         m_fetching = 1'b0;
         m_pc       = 32'd0;
         m_instr    = 32'h0000_0013;
         m_instret  = 32'd0;
      end else if (m_booting) begin
         m_booting  = 1'b0;
         m_fetching = 1'b1;
      end else if (m_fetching) begin
         if (imem_ack) begin
            m_instr    = imem_rdata;
            m_fetching = 1'b0;
         end
      end else if (!stall) begin
         if (pcsrc) m_pc = (m_pc + immext) & 32'hFFFF_FFFC;
         else       m_pc = m_pc + 32'd4;
         m_instret  = m_instret + 32'd1;
         m_fetching = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         logic        holding;
         logic [31:0] pc_b;
         holding = !m_booting && !m_fetching;
         pc_b    = m_pc + 32'hFFFF_FFFC;
         chk("a_imem_req",    32'(a_imem_req),    32'(m_fetching));
         chk("a_imem_addr",   a_imem_addr,        m_pc);
         chk("a_instr_valid", 32'(a_instr_valid), 32'(holding));
         chk("a_instr",       a_instr,            m_instr);
         chk("a_opcode",      32'(a_opcode),      32'(m_instr[6:0]));
         chk("a_funct3",      32'(a_funct3),      32'(m_instr[14:12]));
         chk("a_funct7",      32'(a_funct7),      32'(m_instr[30]));
         chk("a_pc",          a_pc,               m_pc);
         chk("a_pcplus4",     a_pcplus4,          m_pc + 32'd4);
         chk("a_instret",     a_instret,          m_instret);
         chk("b_imem_req",    32'(b_imem_req),    32'(m_fetching));
         chk("b_imem_addr",   b_imem_addr,        pc_b);
         chk("b_instr_valid", 32'(b_instr_valid), 32'(holding));
         chk("b_instr",       b_instr,            m_instr);
         chk("b_pc",          b_pc,               pc_b);
         chk("b_pcplus4",     b_pcplus4,          m_pc);
         chk("b_instret",     b_instret,          m_instret);
      end
   end

   task automatic fetch(input logic [31:0] data, input int waits, input logic [31:0] exp_addr);
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         chk("wait_req", 32'(a_imem_req), 32'd1);
         chk("wait_addr_stable", a_imem_addr, exp_addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_ack   = 1'b0;
      chk("fetch_valid", 32'(a_instr_valid), 32'd1);
      chk("fetch_instr", a_instr, data);
      chk("fetch_pc", a_pc, exp_addr);
   endtask

   task automatic retire(input logic br, input logic [31:0] imm);
      stall  = 1'b0;
      pcsrc  = br;
      immext = imm;
      @(negedge clk);
      stall  = 1'b1;
      pcsrc  = 1'b0;
      immext = 32'd0;
   endtask

   initial begin
      logic [31:0] r;
      #1 reset = 1'b1;
      #2 cmp_en = 1'b1;
      #1 chk("reset_pc_a", a_pc, 32'h0000_0000);
      chk("reset_pc_b", b_pc, 32'hFFFF_FFFC);
      chk("reset_instr", a_instr, 32'h0000_0013);
      chk("reset_req", 32'(a_imem_req), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // First fetch after reset release, ack one cycle after the request.
      @(negedge clk);
      chk("first_req", 32'(a_imem_req), 32'd1);
      chk("first_addr", a_imem_addr, 32'h0000_0000);
      chk("first_state", 32'(a_fsm_state), 32'(REQ));
      imem_ack   = 1'b1;
      imem_rdata = 32'h0050_0093;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("first_valid", 32'(a_instr_valid), 32'd1);
      chk("first_opcode", 32'(a_opcode), 32'h13);
      chk("first_pc", a_pc, 32'h0000_0000);
      chk("first_pcplus4", a_pcplus4, 32'h0000_0004);
      chk("model_pin_instr", m_instr, 32'h0050_0093);

      // Five stalled cycles with stray acks carrying other data.
      for (int i = 0; i < 5; i++) begin
         imem_ack   = (i % 2 == 0);
         imem_rdata = 32'hBAD0_0000 + 32'(i);
         @(negedge clk);
         chk("stall_instr", a_instr, 32'h0050_0093);
         chk("stall_pc", a_pc, 32'h0000_0000);
         chk("stall_instret", a_instret, 32'd0);
         chk("stall_no_req", 32'(a_imem_req), 32'd0);
      end
      imem_ack = 1'b0;

      retire(1'b0, 32'd0);
      chk("seq_addr", a_imem_addr, 32'h0000_0004);
      chk("wrap_addr_b", b_imem_addr, 32'h0000_0000);
      chk("instret_1", a_instret, 32'd1);

      fetch(32'h0000_0033, 3, 32'h0000_0004);
      retire(1'b0, 32'd0);
      fetch(32'h0000_0013, 0, 32'h0000_0008);
      retire(1'b0, 32'd0);
      fetch(32'h0020_8083, 1, 32'h0000_000C);
      retire(1'b0, 32'd0);
      fetch(32'hFE00_0CE3, 0, 32'h0000_0010);
      retire(1'b1, 32'hFFFF_FFF8);
      chk("branch_addr", a_imem_addr, 32'h0000_0008);
      chk("branch_instret", a_instret, 32'd5);
      chk("model_pin_pc", m_pc, 32'h0000_0008);

      fetch(32'h0000_0063, 0, 32'h0000_0008);
      retire(1'b1, 32'h0000_0007);
      chk("branch_mask_addr", a_imem_addr, 32'h0000_000C);

      // Reset in the middle of a pending request, with an ack arriving late.
      @(negedge clk);
      #2 reset = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      #1 chk("rst_async_req", 32'(a_imem_req), 32'd0);
      chk("rst_async_pc", a_pc, 32'h0000_0000);
      chk("rst_async_instret", a_instret, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("late_ack_instr", a_instr, 32'h0000_0013);
      chk("late_ack_valid", 32'(a_instr_valid), 32'd0);
      chk("late_ack_pc_b", b_pc, 32'hFFFF_FFFC);

      // Randomized traffic: stray acks, stalls in every state, occasional resets.
      repeat (2000) begin
         @(negedge clk);
         #1;
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 299) == 0) reset = 1'b1;
         imem_ack   = ($urandom_range(0, 1) == 1);
         imem_rdata = $urandom;
         stall      = ($urandom_range(0, 2) == 0);
         pcsrc      = ($urandom_range(0, 1) == 1);
         r          = $urandom;
         immext     = {{20{r[11]}}, r[11:0]};
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the reset: asynchronous and active-high.
REQ-004 Port imem_req  output  1  SHALL indicate that a fetch request to instruction memory is pending.
REQ-005 Port imem_addr  output  32  SHALL carry the byte address of the fetch, with bits [1:0] always 0.
REQ-006 Port imem_ack  input  1  SHALL mark imem_rdata valid for the pending request.
REQ-007 Port imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-008 Port stall  input  1  SHALL indicate that the decode/execute side holds the current instruction.
REQ-009 Port pcsrc  input  1  SHALL be the branch-taken decision for the instruction currently presented.
REQ-010 Port immext  input  32  SHALL be the sign-extended branch offset for the instruction currently presented.
REQ-011 Port instr  output  32  SHALL be the registered instruction word presented to decode.
REQ-012 Port opcode  output  7  SHALL be instr[6:0]. Port funct3  output  3  SHALL be instr[14:12]. Port funct7  output  1  SHALL be instr[30].
REQ-013 Port instr_valid  output  1  SHALL be high while instr holds a fetched, unretired instruction.
REQ-014 Port pc  output  32  SHALL be the address of instr. Port pcplus4  output  32  SHALL be pc+4.
REQ-015 Port instret  output  32  SHALL count retired instructions.

Function
REQ-016 FSM states SHALL be IDLE, REQ, VALID.
REQ-017 IDLE SHALL hold for exactly one cycle after reset release, then go to REQ.
- REQ: imem_req=1, imem_addr=pc.
- On imem_ack: capture imem_rdata into instr, go to VALID.
REQ-018 imem_addr SHALL remain stable while imem_req is high and imem_ack is low.
REQ-019 imem_ack SHALL be ignored in IDLE and VALID.
REQ-020 VALID SHALL hold instr_valid=1 and imem_req=0.
- stall=1: instr, pc, and instret SHALL hold.
- stall=0 (retire): pc SHALL load pc+immext if pcsrc=1, else pc+4; instret SHALL increment by 1; state SHALL go to REQ.
REQ-021 stall SHALL have no effect in IDLE or REQ.
REQ-022 Minimum latency SHALL be 1 cycle from imem_ack to instr_valid.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.
REQ-023 PC arithmetic SHALL be 32-bit modulo: 0xFFFF_FFFC+4 = 0x0000_0000.
- Branch target bits [1:0] SHALL be forced to 0.
REQ-024 instret SHALL wrap from 0xFFFF_FFFF to 0.
REQ-025 pcsrc and immext SHALL be sampled only on the retire edge.

Reset
REQ-026 Asserting reset SHALL immediately force all outputs and state, regardless of state:
- state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, instret=0.
REQ-027 A request pending when reset asserts SHALL be abandoned.
- A late imem_ack SHALL NOT update instr.

Structure
REQ-028 A shared package riscv_pkg SHALL hold:
- opcode constants (7'b0110011 R-type, 7'b0000011 load, 7'b0100011 store, 7'b1100011 branch)
- the NOP word 32'h0000_0013
- the fetch state enumeration.
REQ-029 Next-PC selection (pc+4 vs pc+immext, bit masking) SHALL be one sub-module, pc_next_mux.
- All registers SHALL remain in fetch_unit.

Verification
REQ-030 Reset release, RESET_PC=0, ack 1 cycle after req, rdata=0x00500093 -> imem_addr=0; instr_valid on next cycle; opcode=0x13, pc=0.
REQ-031 Branch retire: pc=0x10, pcsrc=1, immext=0xFFFFFFF8, stall=0 -> next imem_addr=0x08; instret+1.
REQ-032 stall=1 for 5 cycles in VALID -> instr, pc, instret unchanged; no imem_req until stall=0.
REQ-033 Wait states: ack delayed 3 cycles -> imem_addr stable throughout; a stray ack during VALID is ignored.
REQ-034 Wrap: RESET_PC=0xFFFF_FFFC, retire with pcsrc=0 -> next fetch at 0x0000_0000.
REQ-035 reset asserted mid-REQ, then ack arrives -> instr=0x00000013, instr_valid=0, pc=RESET_PC.
